// File: rtl/bit_serial_addsub.sv
// bit_serial_addsub: WIDTH-cycle adder/subtractor built around a single full
// adder/subtractor cell and a carry/borrow flip-flop, operands processed LSB
// first. A start accepted in IDLE launches an operation. The result and the
// final carry/borrow are published together with a one-cycle done pulse.
//
// Handshake: start is sampled only while busy is low. The edge that samples
// start high is the accept edge. busy stays high for exactly WIDTH cycles after
// that edge. done pulses for one cycle when result and carryborrow_out become
// valid. busy and done are never high together.
//
// Optional feature: define ADDSUB_OVERFLOW_EN to add the overflow port. This
// port reports signed overflow and is held with the result.
module bit_serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode_addsub,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
`ifdef ADDSUB_OVERFLOW_EN
    output logic             carryborrow_out,
    output logic             overflow
`else
    output logic             carryborrow_out
`endif
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // state is the hook for external checkers observing the FSM
    state_t state, next_state;

    logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_next;
    logic [CNT_W-1:0] bit_cnt;
    logic             sub_q;
    logic             cb_q;
    logic             a_bit, b_bit, sum_bit, cb_next;
    logic             last_bit, accept;

`ifdef ADDSUB_OVERFLOW_EN
    logic             a_msb, b_msb;
    logic             ov_next;
`endif

    assign accept   = (state == IDLE) && start;
    assign last_bit = (state == RUN) && (bit_cnt == CNT_W'(WIDTH - 1));
    assign busy     = (state == RUN);

    // Single arithmetic cell acting on the current LSBs and the carry/borrow flip-flop
    always_comb begin
        a_bit    = a_sr[0];
        b_bit    = b_sr[0];
        sum_bit  = a_bit ^ b_bit ^ cb_q;
        cb_next  = sub_q ? ((~a_bit & b_bit) | (cb_q & ~(a_bit ^ b_bit)))
                         : ((a_bit & b_bit) | (cb_q & (a_bit ^ b_bit)));
        res_next = {sum_bit, res_sr[WIDTH-1:1]};
    end

`ifdef ADDSUB_OVERFLOW_EN
    // Signed overflow from the latched operand MSBs and the final sum bit
    always_comb begin
        ov_next = 1'b0;
        if (sub_q)
            ov_next = (a_msb != b_msb) && (sum_bit != a_msb);
        else
            ov_next = (a_msb == b_msb) && (sum_bit != a_msb);
    end
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state logic: IDLE -> RUN on start, RUN -> IDLE on the last bit
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (last_bit) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: latch on accept, shift one bit per RUN edge, publish on the last bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr            <= '0;
            b_sr            <= '0;
            res_sr          <= '0;
            bit_cnt         <= '0;
            sub_q           <= 1'b0;
            cb_q            <= 1'b0;
            result          <= '0;
            carryborrow_out <= 1'b0;
            done            <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_sr    <= operand_a;
                b_sr    <= operand_b;
                sub_q   <= mode_addsub;
                cb_q    <= 1'b0;
                bit_cnt <= '0;
            end else if (state == RUN) begin
                a_sr    <= a_sr >> 1;
                b_sr    <= b_sr >> 1;
                cb_q    <= cb_next;
                res_sr  <= res_next;
                bit_cnt <= bit_cnt + CNT_W'(1);
                if (last_bit) begin
                    result          <= res_next;
                    carryborrow_out <= cb_next;
                    done            <= 1'b1;
                end
            end
        end
    end

`ifdef ADDSUB_OVERFLOW_EN
    // Operand MSBs captured at accept, overflow published with the result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                a_msb <= operand_a[WIDTH-1];
                b_msb <= operand_b[WIDTH-1];
            end else if (last_bit) begin
                overflow <= ov_next;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bit_serial_addsub.sv
// Directed-vector bench for bit_serial_addsub (WIDTH = 8).
module tb_bit_serial_addsub;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic             mode_addsub;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carryborrow_out;
`ifdef ADDSUB_OVERFLOW_EN
    logic             overflow;
`endif

    int n_vec;
    int n_err;

    logic [WIDTH-1:0] last_r;
    logic             last_c;

    bit_serial_addsub #(.WIDTH(WIDTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .mode_addsub     (mode_addsub),
        .operand_a       (operand_a),
        .operand_b       (operand_b),
        .busy            (busy),
        .done            (done),
        .result          (result),
`ifdef ADDSUB_OVERFLOW_EN
        .carryborrow_out (carryborrow_out),
        .overflow        (overflow)
`else
        .carryborrow_out (carryborrow_out)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive start for one cycle at a negedge. Returns at the negedge after the accept edge.
    task automatic launch(input logic m, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        mode_addsub = m;
        operand_a   = a;
        operand_b   = b;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        // scramble inputs; the latched copies must be used
        operand_a   = ~a;
        operand_b   = ~b;
        mode_addsub = ~m;
    endtask

    // Observe WIDTH busy cycles, then check the done cycle. ign_k >= 0 pulses an
    // ignored start (A=B=0xFF) at the sample after edge ign_k. Returns at the
    // negedge of the done cycle.
    task automatic finish(input string tag, input logic [WIDTH-1:0] er, input logic ec,
                          input logic ev, input int ign_k);
        int nb, nd, nh;
        nb = 0; nd = 0; nh = 0;
        for (int k = 0; k < WIDTH; k++) begin
            if (k == ign_k) begin
                start = 1'b1; operand_a = 8'hFF; operand_b = 8'hFF; mode_addsub = 1'b0;
            end else begin
                start = 1'b0;
            end
            if (busy === 1'b1) nb++;
            if (done !== 1'b0) nd++;
            if (result !== last_r || carryborrow_out !== last_c) nh++;
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, "_busy_cycles"}, nb, WIDTH);
        check({tag, "_early_done"}, nd, 0);
        check({tag, "_held_while_busy"}, nh, 0);
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_busy_low"}, busy, 1'b0);
        check({tag, "_result"}, result, er);
        check({tag, "_cb"}, carryborrow_out, ec);
`ifdef ADDSUB_OVERFLOW_EN
        check({tag, "_ovf"}, overflow, ev);
`else
        if (ev === 1'bx) $display("unused overflow expectation");
`endif
        last_r = er;
        last_c = ec;
    endtask

    initial begin
        int nd;
        n_vec = 0; n_err = 0;
        last_r = '0; last_c = 1'b0;
        rst = 1'b1; start = 1'b0; mode_addsub = 1'b0;
        operand_a = '0; operand_b = '0;

        // reset state
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_result", result, 0);
        check("rst_cb", carryborrow_out, 1'b0);
`ifdef ADDSUB_OVERFLOW_EN
        check("rst_ovf", overflow, 1'b0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 0x5A + 0x3C
        launch(1'b0, 8'h5A, 8'h3C); finish("add_5a_3c", 8'h96, 1'b0, 1'b1, -1);
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
        check("result_held", result, 8'h96);
        // 0x10 - 0x20
        launch(1'b1, 8'h10, 8'h20); finish("sub_10_20", 8'hF0, 1'b1, 1'b0, -1);
        @(negedge clk);
        // 0xFF + 0x01
        launch(1'b0, 8'hFF, 8'h01); finish("add_ff_01", 8'h00, 1'b1, 1'b0, -1);
        @(negedge clk);
        // 0x80 - 0x01
        launch(1'b1, 8'h80, 8'h01); finish("sub_80_01", 8'h7F, 1'b0, 1'b1, -1);
        @(negedge clk);
        // 0x7F + 0x01
        launch(1'b0, 8'h7F, 8'h01); finish("add_7f_01", 8'h80, 1'b0, 1'b1, -1);
        @(negedge clk);
        // 0x33 - 0x33
        launch(1'b1, 8'h33, 8'h33); finish("sub_eq", 8'h00, 1'b0, 1'b0, -1);
        @(negedge clk);
        // 0x00 - 0x01
        launch(1'b1, 8'h00, 8'h01); finish("sub_00_01", 8'hFF, 1'b1, 1'b0, -1);
        @(negedge clk);

        // 0x01 + 0x02 with an ignored start after edge 3, then back-to-back 0x0F + 0x01
        launch(1'b0, 8'h01, 8'h02); finish("add_ign", 8'h03, 1'b0, 1'b0, 3);
        launch(1'b0, 8'h0F, 8'h01); finish("add_b2b", 8'h10, 1'b0, 1'b0, -1);
        @(negedge clk);

        // asynchronous reset mid-run after edge 3
        launch(1'b0, 8'h5A, 8'h3C);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_result", result, 0);
        check("abort_cb", carryborrow_out, 1'b0);
`ifdef ADDSUB_OVERFLOW_EN
        check("abort_ovf", overflow, 1'b0);
`endif
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int k = 0; k < WIDTH + 3; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) nd++;
        end
        check("abort_no_done", nd, 0);
        last_r = '0; last_c = 1'b0;
        launch(1'b0, 8'h5A, 8'h3C); finish("after_abort", 8'h96, 1'b0, 1'b1, -1);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
